result_serializer: RTL and testbench
====================================

RESULT_SERIALIZER -- requirements
Module: result_serializer

Interface
REQ-001 Parameter NUM_RESULTS, default 8, SHALL set the number of 8-bit id slots (legal 2..16).
REQ-002 Parameter EMPTY_ID, default 8'hFF, SHALL mark an unused id slot.
REQ-003 aclk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 areset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 ids  input  NUM_RESULTS*8  SHALL carry the accumulator result ids; slot i at bits [8i+7:8i], slot 0 is the best.
REQ-006 skip_empty  input  1  SHALL drop EMPTY_ID slots from the frame when 1; sampled together with ids.
REQ-007 start  input  1  SHALL be a single-cycle request to emit one frame.
REQ-008 m_axis_tvalid  output  1  SHALL mark a valid output byte.
REQ-009 m_axis_tready  input  1  SHALL be the downstream accept signal.
REQ-010 m_axis_tdata  output  8  SHALL be the output byte.
REQ-011 m_axis_tlast  output  1  SHALL mark the final byte of a frame.
REQ-012 busy  output  1  SHALL be high from the cycle after an accepted start until the cycle after the last beat transfers.

Function
REQ-013 States SHALL be IDLE, HEADER and DATA.
REQ-014 In IDLE with start=1, the block SHALL snapshot ids and skip_empty into internal registers and go to HEADER next cycle.
REQ-015 A start while not in IDLE SHALL be ignored; the snapshot SHALL NOT change mid-frame.
REQ-016 A frame SHALL be one header byte followed by the selected ids, in ascending slot order.
REQ-017 Selection: all NUM_RESULTS slots when skip_empty=0; otherwise only slots not equal to EMPTY_ID.
REQ-018 The header byte SHALL equal the count of selected slots, 0..NUM_RESULTS, zero-extended to 8 bits.
REQ-019 A beat SHALL transfer on a cycle with m_axis_tvalid=1 and m_axis_tready=1.
REQ-020 m_axis_tvalid SHALL be 1 throughout HEADER and DATA and 0 in IDLE.
REQ-021 While tvalid=1 and tready=0, tdata and tlast SHALL hold stable.
REQ-022 tvalid SHALL NOT depend combinationally on tready.
REQ-023 HEADER SHALL drive the count byte into tdata in its first cycle, with tlast=1 iff count=0.
REQ-024 HEADER transfer with count=0 SHALL go to IDLE; with count>0 SHALL go to DATA.
REQ-025 DATA SHALL present the next selected slot per beat.
REQ-026 Skipped slots SHALL cost zero bus cycles, so selected ids go out back-to-back when tready=1.
REQ-027 tlast SHALL be 1 exactly on the last selected id.
REQ-028 The transfer of that last id SHALL return the block to IDLE.
REQ-029 Throughput SHALL be one beat per cycle with tready=1 held high.
REQ-030 Start-to-first-tvalid latency SHALL be exactly 1 cycle.
REQ-031 The cycle after the final transfer SHALL be IDLE, so a start there is accepted.
REQ-032 A minimum frame SHALL take count+1 beats plus 1 start cycle.
REQ-033 A start in the same cycle as the final transfer SHALL be ignored (block not yet IDLE).
REQ-034 Live changes on ids or skip_empty during a frame SHALL NOT affect the frame.

Reset
REQ-035 areset=1 SHALL immediately force IDLE, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=8'h00 and busy=0, and SHALL clear the snapshot.
REQ-036 Reset mid-frame SHALL abandon the frame; no partial continuation after release.
REQ-037 The first start SHALL be accepted on the first rising edge after areset deasserts.

Verification
REQ-038 NUM_RESULTS=8, ids={07,06,05,04,03,02,01,00} (slot0=00), skip_empty=0, tready=1, pulse start -> 9 consecutive beats 08,00,01,..,07; tlast on 07; busy drops the next cycle.
REQ-039 Slots 0..2=0A,0B,0C, others FF, skip_empty=1 -> beats 03,0A,0B,0C; tlast on 0C; no gap cycles.
REQ-040 All slots FF, skip_empty=1 -> single beat 00 with tlast=1, then IDLE.
REQ-041 Case REQ-038 with tready toggling 1,0,0,1 repeatedly, and ids changed to all 55 after start -> same 9 bytes in order, tdata stable during stalls, no 55 emitted.
REQ-042 start pulsed during DATA and again on the tlast transfer cycle -> both ignored; start one cycle later -> new frame begins, tvalid one cycle after.
REQ-043 areset asserted asynchronously between edges after beat 3 of a frame -> tvalid/busy go 0 at once; after release, no beats until a new start, whose frame begins with the header.

Source files
------------

// File: rtl/result_serializer.sv
// result_serializer: emits a count header followed by the selected result ids as one AXI-Stream frame.
module result_serializer #(
  parameter int         NUM_RESULTS = 8,
  parameter logic [7:0] EMPTY_ID    = 8'hFF
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [NUM_RESULTS*8-1:0] ids,
  input  logic                     skip_empty,
  input  logic                     start,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [7:0]               m_axis_tdata,
  output logic                     m_axis_tlast,
  output logic                     busy
);
  localparam int IW = $clog2(NUM_RESULTS);
  typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;
  state_t                   state_q, state_d;
  logic [NUM_RESULTS*8-1:0] ids_q, ids_d;
  logic [NUM_RESULTS-1:0]   mask_q, mask_d, sel;
  logic [7:0]               cnt_q, cnt_d, sel_cnt;
  logic [IW-1:0]            idx_q, idx_d, first_idx, nxt_idx;
  logic                     nxt_found;
  always_comb begin
    sel = '0;
    sel_cnt = 8'd0;
    for (int i = 0; i < NUM_RESULTS; i++) begin
      sel[i] = !skip_empty || ids[8*i +: 8] != EMPTY_ID;
      sel_cnt = sel_cnt + 8'(sel[i]);
    end
  end
  // Downward scan so the lowest matching slot wins; skipped slots never occupy a bus cycle.
  always_comb begin
    first_idx = '0;
    nxt_idx = '0;
    nxt_found = 1'b0;
    for (int i = NUM_RESULTS - 1; i >= 0; i--) begin
      if (mask_q[i]) first_idx = IW'(i);
      if (mask_q[i] && i > int'(idx_q)) begin
        nxt_found = 1'b1;
        nxt_idx = IW'(i);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    ids_d = ids_q;
    mask_d = mask_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    m_axis_tdata = 8'h00;
    m_axis_tlast = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = HEADER;
        ids_d = ids;
        mask_d = sel;
        cnt_d = sel_cnt;
      end
      HEADER: begin
        m_axis_tdata = cnt_q;
        m_axis_tlast = cnt_q == 8'd0;
        if (m_axis_tready) begin
          state_d = m_axis_tlast ? IDLE : DATA;
          idx_d = first_idx;
        end
      end
      DATA: begin
        m_axis_tdata = ids_q[{idx_q, 3'b000} +: 8];
        m_axis_tlast = !nxt_found;
        if (m_axis_tready) begin
          state_d = nxt_found ? DATA : IDLE;
          idx_d = nxt_found ? nxt_idx : idx_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign m_axis_tvalid = state_q != IDLE;
  assign busy = state_q != IDLE;
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      ids_q <= '0;
      mask_q <= '0;
      cnt_q <= 8'd0;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      ids_q <= ids_d;
      mask_q <= mask_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end
endmodule

// File: tb/tb_result_serializer.sv
// tb_result_serializer: directed frames checked by a scoreboard queue and a decoupled beat monitor.
module tb_result_serializer;
  localparam int N = 8;
  logic aclk = 1'b0, areset = 1'b1, skip_empty = 1'b0, start = 1'b0, tready = 1'b1;
  logic tvalid, tlast, busy;
  logic [7:0] tdata;
  logic [N*8-1:0] ids = '0;
  logic [8:0] exp_q[$];
  logic [8:0] held;
  logic stalled = 1'b0, tog_en = 1'b0;
  int checks = 0, fails = 0;
  always #5 aclk = ~aclk;
  result_serializer #(.NUM_RESULTS(N), .EMPTY_ID(8'hFF)) dut (
    .aclk(aclk), .areset(areset), .ids(ids), .skip_empty(skip_empty), .start(start),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tdata(tdata),
    .m_axis_tlast(tlast), .busy(busy)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic pushb(input logic [7:0] b, input logic l);
    exp_q.push_back({l, b});
  endtask
  task automatic push_seq_frame();
    pushb(8'h08, 1'b0);
    for (int i = 0; i < 8; i++) pushb(8'(i), i == 7);
  endtask
  task automatic set_seq_ids();
    for (int i = 0; i < N; i++) ids[8*i +: 8] = 8'(i);
  endtask
  task automatic pulse_start();
    start = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask
  task automatic run(input string name, input int exp);
    int n = 0;
    while (n < 200) begin
      @(negedge aclk);
      if (!busy) break;
      n++;
    end
    if (exp >= 0) chk(name, n, exp);
    else chk({name, "_timeout"}, 32'(n < 200), 1);
  endtask
  always @(negedge aclk) begin
    if (!areset && tvalid) begin
      if (stalled) chk("stall_hold", {tlast, tdata}, held);
      if (tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_beat: got %0h expected no beat", {tlast, tdata});
        end else chk("beat", {tlast, tdata}, exp_q.pop_front());
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held = {tlast, tdata};
      end
    end else stalled = 1'b0;
  end
  initial begin
    int k = 0;
    forever begin
      @(posedge aclk); #1;
      if (tog_en) begin
        tready = (k % 4 == 0) || (k % 4 == 3);
        k++;
      end else tready = 1'b1;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    #12;
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_busy", busy, 0);
    @(negedge aclk);
    areset = 1'b0;
    set_seq_ids();
    push_seq_frame();
    pulse_start();
    chk("t1_latency", tvalid, 1);
    run("t1_cycles", 9);
    ids = {N{8'hFF}};
    ids[23:0] = 24'h0C0B0A;
    skip_empty = 1'b1;
    pushb(8'h03, 1'b0);
    pushb(8'h0A, 1'b0);
    pushb(8'h0B, 1'b0);
    pushb(8'h0C, 1'b1);
    pulse_start();
    run("t2_cycles", 4);
    ids = {N{8'hFF}};
    pushb(8'h00, 1'b1);
    pulse_start();
    run("t3_cycles", 1);
    skip_empty = 1'b0;
    set_seq_ids();
    push_seq_frame();
    tog_en = 1'b1;
    pulse_start();
    ids = {N{8'h55}};
    skip_empty = 1'b1;
    run("t4_stall", -1);
    tog_en = 1'b0;
    skip_empty = 1'b0;
    set_seq_ids();
    push_seq_frame();
    push_seq_frame();
    pulse_start();
    step(3);
    pulse_start();
    step(4);
    pulse_start();
    chk("t5_idle_after_last", tvalid, 0);
    pulse_start();
    chk("t5_restart_latency", tvalid, 1);
    run("t5_cycles", 9);
    pushb(8'h08, 1'b0);
    pushb(8'h00, 1'b0);
    pushb(8'h01, 1'b0);
    pulse_start();
    step(3);
    #2 areset = 1'b1;
    #1;
    chk("t6_rst_tvalid", tvalid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_tdata", tdata, 0);
    repeat (2) @(posedge aclk);
    #3 areset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("t6_no_resume", tvalid, 0);
    end
    ids = {N{8'hFF}};
    ids[23:0] = 24'h0C0B0A;
    skip_empty = 1'b1;
    pushb(8'h03, 1'b0);
    pushb(8'h0A, 1'b0);
    pushb(8'h0B, 1'b0);
    pushb(8'h0C, 1'b1);
    pulse_start();
    run("t6_new_frame", 4);
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
